// File: rtl/param_stall_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : param_stall_pipe_pkg
//  Purpose  : Shared helpers for the stall pipeline: the per-stage affine
//             operation and the occupancy-counter width.
//  Revision : 1.0 - initial release
// ============================================================================
package param_stall_pipe_pkg;

   // Widest data path the stage op supports. The product of two operands
   // needs 2*W bits, and the op works at 64 bits.
   localparam int c_max_w = 32;

   // Affine stage operation on a W-bit value carried in a 64-bit container.
   // The product is formed exactly (both operands fit in 32 bits), then
   // reduced modulo 2^w. Pass-through still masks so the caller sees a
   // clean W-bit result in the low bits.
   function automatic logic [63:0] stage_op(
      input logic [63:0] x,
      input logic        mode,
      input int          w,
      input logic [31:0] mul,
      input logic [31:0] add
   );
      logic [63:0] mask;
      logic [63:0] xm;
      logic [63:0] prod;
      mask = (64'd1 << w) - 64'd1;
      xm   = x & mask;
      prod = xm * {32'd0, mul} + {32'd0, add};
      stage_op = mode ? (prod & mask) : xm;
   endfunction

   // Bits needed to hold an occupancy of 0..depth.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/param_stall_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage
//  Purpose  : One pipeline stage. Holds vld/dat/mode/tag and loads from its
//             source when the source is valid, the stage is not stalled, and
//             the stage is either empty or draining this cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage
   import param_stall_pipe_pkg::*;
#(
   parameter int W   = 4,
   parameter int MUL = 2,
   parameter int ADD = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         src_vld,
   input  logic [W-1:0] src_data,
   input  logic         src_mode,
   input  logic         src_tag,
   input  logic         stall,
   input  logic         leave,
   output logic         go,
   output logic         vld,
   output logic [W-1:0] dat,
   output logic         mode,
   output logic         tag
);

   logic         vld_q,  vld_d;
   logic [W-1:0] dat_q,  dat_d;
   logic         mode_q, mode_d;
   logic         tag_q,  tag_d;
   logic [63:0]  w_op;
   logic         w_unused_op;

   // Load condition: source present, not stalled, room now or freed this cycle.
   always_comb go = src_vld & ~stall & (~vld_q | leave);

   // Stage op on the incoming value, using the mode travelling with it.
   always_comb w_op = stage_op(64'(src_data), src_mode, W, 32'(MUL), 32'(ADD));

   // Upper bits of the 64-bit op result are always zero for W <= 32.
   always_comb w_unused_op = ^w_op[63:W];

   // Next state: load wins over leave so a simultaneous drain+load keeps vld.
   always_comb begin
      vld_d  = vld_q;
      dat_d  = dat_q;
      mode_d = mode_q;
      tag_d  = tag_q;
      if (go) begin
         vld_d  = 1'b1;
         dat_d  = w_op[W-1:0];
         mode_d = src_mode;
         tag_d  = src_tag;
      end else if (leave) begin
         vld_d  = 1'b0;
      end
   end

   // Stage registers; reset clears the whole payload, not just the valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= 1'b0;
         dat_q  <= '0;
         mode_q <= 1'b0;
         tag_q  <= 1'b0;
      end else begin
         vld_q  <= vld_d;
         dat_q  <= dat_d;
         mode_q <= mode_d;
         tag_q  <= tag_d;
      end
   end

   assign vld  = vld_q;
   assign dat  = dat_q;
   assign mode = mode_q;
   assign tag  = tag_q;

endmodule
`default_nettype wire

// File: rtl/param_stall_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : param_stall_pipe
//  Purpose  : DEPTH-stage in-order pipeline with valid/ready at both ends,
//             a per-stage stall input, and a tag bit riding with each
//             transaction. Each stage optionally applies x*MUL+ADD mod 2^W.
//  Revision : 1.0 - initial release
// ============================================================================
module param_stall_pipe
   import param_stall_pipe_pkg::*;
#(
   parameter int W     = 4,   // data width, 1..32
   parameter int DEPTH = 3,   // number of stages, >= 2
   parameter int MUL   = 2,
   parameter int ADD   = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [W-1:0]                  in_data,
   input  logic                          in_mode,
   input  logic                          in_tag,
   input  logic [DEPTH-1:0]              stall_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [W-1:0]                  out_data,
   output logic                          out_tag,
   output logic [cnt_width(DEPTH)-1:0]   count
);

   localparam int C_CNT_W = cnt_width(DEPTH);

   logic [DEPTH-1:0] w_vld;
   logic [DEPTH-1:0] w_go;
   logic [DEPTH-1:0] w_leave;
   logic [DEPTH-1:0] w_mode;
   logic [DEPTH-1:0] w_tag;
   logic [W-1:0]     w_dat [DEPTH];

   logic [C_CNT_W-1:0] count_q, count_d;

   // Ready chain, evaluated from the output back toward stage 0 so a full
   // pipe can accept and drain in the same cycle without a bubble.
   always_comb begin
      w_leave = '0;
      w_leave[DEPTH-1] = w_vld[DEPTH-1] & out_ready;
      for (int i = DEPTH - 2; i >= 0; i--) begin
         w_leave[i] = w_vld[i] & ~stall_in[i+1] & (~w_vld[i+1] | w_leave[i+1]);
      end
   end

   // Stage 0 accepts when not stalled and empty or draining.
   always_comb in_ready = ~stall_in[0] & (~w_vld[0] | w_leave[0]);

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic         w_src_vld;
         logic [W-1:0] w_src_dat;
         logic         w_src_mode;
         logic         w_src_tag;

         if (gi == 0) begin : g_src_in
            assign w_src_vld  = in_valid;
            assign w_src_dat  = in_data;
            assign w_src_mode = in_mode;
            assign w_src_tag  = in_tag;
         end else begin : g_src_prev
            assign w_src_vld  = w_vld[gi-1];
            assign w_src_dat  = w_dat[gi-1];
            assign w_src_mode = w_mode[gi-1];
            assign w_src_tag  = w_tag[gi-1];
         end

         pipe_stage #(
            .W   (W),
            .MUL (MUL),
            .ADD (ADD)
         ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .src_vld  (w_src_vld),
            .src_data (w_src_dat),
            .src_mode (w_src_mode),
            .src_tag  (w_src_tag),
            .stall    (stall_in[gi]),
            .leave    (w_leave[gi]),
            .go       (w_go[gi]),
            .vld      (w_vld[gi]),
            .dat      (w_dat[gi]),
            .mode     (w_mode[gi]),
            .tag      (w_tag[gi])
         );
      end
   endgenerate

   // Occupancy: +1 on entry, -1 on exit, unchanged when both or neither.
   always_comb begin
      count_d = count_q;
      unique case ({w_go[0], w_leave[DEPTH-1]})
         2'b10:   count_d = count_q + C_CNT_W'(1);
         2'b01:   count_d = count_q - C_CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Occupancy register.
   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign out_valid = w_vld[DEPTH-1];
   assign out_data  = w_dat[DEPTH-1];
   assign out_tag   = w_tag[DEPTH-1];
   assign count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_param_stall_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_stall_pipe
//  Purpose  : Self-checking bench for param_stall_pipe (W=4, DEPTH=3,
//             MUL=2, ADD=1) against a transaction-level reference queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_param_stall_pipe;

   localparam int W     = 4;
   localparam int DEPTH = 3;
   localparam int MUL   = 2;
   localparam int ADD   = 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_data;
   logic             in_mode;
   logic             in_tag;
   logic [DEPTH-1:0] stall_in;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_data;
   logic             out_tag;
   logic [1:0]       count;

   int n_vec = 0;
   int n_err = 0;

   // Reference: expected results in acceptance order.
   int q_data[$];
   bit q_tag[$];

   // Per-cycle observations captured just before the active edge.
   logic         acc, drn, obs_ready, underflow;
   logic [W-1:0] obs_data, exp_data, hold_data;
   logic         obs_tag, exp_tag, hold_tag, hold_prev;

   param_stall_pipe #(.W(W), .DEPTH(DEPTH), .MUL(MUL), .ADD(ADD)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .in_tag    (in_tag),
      .stall_in  (stall_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .count     (count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int ref_op(input int x, input bit m);
      return m ? (x * MUL + ADD) % (1 << W) : x;
   endfunction

   function automatic int ref_pipe(input int x, input bit m);
      int v;
      v = x;
      for (int k = 0; k < DEPTH; k++) v = ref_op(v, m);
      return v;
   endfunction

   // Advance one clock: record handshakes, update the reference queue.
   task automatic tick();
      #1;
      obs_ready = in_ready;
      acc       = in_valid & in_ready & ~rst;
      drn       = out_valid & out_ready & ~rst;
      obs_data  = out_data;
      obs_tag   = out_tag;
      hold_prev = out_valid & ~out_ready & ~rst;
      hold_data = out_data;
      hold_tag  = out_tag;
      underflow = 1'b0;
      if (drn) begin
         if (q_data.size() == 0) underflow = 1'b1;
         else begin
            exp_data = W'(q_data.pop_front());
            exp_tag  = q_tag.pop_front();
         end
      end
      if (acc) begin
         q_data.push_back(ref_pipe(int'(in_data), in_mode));
         q_tag.push_back(in_tag);
      end
      if (rst) begin
         q_data.delete();
         q_tag.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 0; in_data = '0; in_mode = 0; in_tag = 0;
      stall_in = '0; out_ready = 1;
   endtask

   task automatic test_reset();
      rst = 1; idle_inputs();
      tick(); tick();
      rst = 0;
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_vec++; if (out_data !== 4'd0) begin n_err++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
      n_vec++; if (out_tag !== 1'b0) begin n_err++; $display("FAIL reset_out_tag: got %b want 0", out_tag); end
      n_vec++; if (count !== 2'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      stall_in = 3'b001; #1;
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready_stalled: got %b want 0", in_ready); end
      stall_in = '0;
   endtask

   task automatic test_basic();
      idle_inputs();
      in_valid = 1; in_data = 4'd0; in_mode = 1; tick();
      in_data = 4'd5; tick();
      in_data = 4'd9; in_mode = 0; tick();
      n_vec++; if (out_valid !== 1'b1 || out_data !== 4'd7) begin n_err++; $display("FAIL basic_first: got v=%b d=%0d want v=1 d=7", out_valid, out_data); end
      n_vec++; if (count !== 2'd3) begin n_err++; $display("FAIL basic_count_peak: got %0d want 3", count); end
      in_valid = 0; tick();
      n_vec++; if (out_data !== 4'd15 || count !== 2'd2) begin n_err++; $display("FAIL basic_second: got d=%0d c=%0d want d=15 c=2", out_data, count); end
      tick();
      n_vec++; if (out_data !== 4'd9 || count !== 2'd1) begin n_err++; $display("FAIL basic_passthru: got d=%0d c=%0d want d=9 c=1", out_data, count); end
      tick();
      n_vec++; if (out_valid !== 1'b0 || count !== 2'd0) begin n_err++; $display("FAIL basic_empty: got v=%b c=%0d want v=0 c=0", out_valid, count); end
      in_valid = 1; in_data = 4'd3; in_mode = 1; tick();
      in_valid = 0; tick(); tick();
      n_vec++; if (out_valid !== 1'b1 || out_data !== 4'd15) begin n_err++; $display("FAIL basic_three: got v=%b d=%0d want v=1 d=15", out_valid, out_data); end
      tick();
   endtask

   task automatic test_full();
      idle_inputs(); out_ready = 0;
      in_valid = 1; in_mode = 0;
      in_data = 4'd1; tick();
      in_data = 4'd2; tick();
      in_data = 4'd3; tick();
      n_vec++; if (count !== 2'd3 || out_data !== 4'd1) begin n_err++; $display("FAIL full_fill: got c=%0d d=%0d want c=3 d=1", count, out_data); end
      in_data = 4'd4; #1;
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
      tick();
      n_vec++; if (acc !== 1'b0 || out_valid !== 1'b1 || out_data !== 4'd1 || count !== 2'd3) begin n_err++; $display("FAIL full_hold: got acc=%b v=%b d=%0d c=%0d want 0 1 1 3", acc, out_valid, out_data, count); end
      out_ready = 1; tick();
      n_vec++; if (acc !== 1'b1 || drn !== 1'b1 || count !== 2'd3 || out_data !== 4'd2) begin n_err++; $display("FAIL full_passthrough: got acc=%b drn=%b c=%0d d=%0d want 1 1 3 2", acc, drn, count, out_data); end
      in_valid = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (drn) begin
            n_vec++; if (underflow || obs_data !== exp_data) begin n_err++; $display("FAIL full_drain: got %0d want %0d (underflow=%b)", obs_data, exp_data, underflow); end
         end
      end
      n_vec++; if (count !== 2'd0 || q_data.size() != 0) begin n_err++; $display("FAIL full_drained: got c=%0d pending=%0d want 0 0", count, q_data.size()); end
   endtask

   task automatic test_stall();
      int n_out;
      idle_inputs(); n_out = 0;
      in_valid = 1; in_data = 4'd6; in_mode = 1; tick();
      in_data = 4'd10; in_mode = 0; tick();
      stall_in = 3'b010; in_data = 4'd12; in_mode = 1;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_vec++; if (obs_ready !== 1'b0 || acc !== 1'b0) begin n_err++; $display("FAIL stall_in_ready: cycle %0d got rdy=%b want 0", k, obs_ready); end
         if (drn) begin
            n_out++;
            n_vec++; if (underflow || obs_data !== exp_data) begin n_err++; $display("FAIL stall_order: got %0d want %0d", obs_data, exp_data); end
         end
      end
      stall_in = '0; tick();
      if (drn) n_out++;
      in_valid = 0;
      for (int k = 0; k < 10 && q_data.size() != 0; k++) begin
         tick();
         if (drn) begin
            n_out++;
            n_vec++; if (underflow || obs_data !== exp_data) begin n_err++; $display("FAIL stall_order: got %0d want %0d", obs_data, exp_data); end
         end
      end
      tick();
      n_vec++; if (n_out != 3 || out_valid !== 1'b0 || count !== 2'd0) begin n_err++; $display("FAIL stall_count: got outs=%0d v=%b c=%0d want 3 0 0", n_out, out_valid, count); end
   endtask

   task automatic test_tag();
      int n_tag;
      idle_inputs(); n_tag = 0;
      in_valid = 1; in_mode = 1;
      in_data = 4'd1; in_tag = 0; tick();
      in_data = 4'd2; in_tag = 1; tick();
      in_data = 4'd8; in_tag = 0; in_mode = 0; tick();
      in_valid = 0; in_tag = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (drn) begin
            if (obs_tag) n_tag++;
            n_vec++; if (obs_tag !== (obs_data == 4'd7)) begin n_err++; $display("FAIL tag_align: got tag=%b data=%0d want tag only with 7", obs_tag, obs_data); end
         end
      end
      n_vec++; if (n_tag != 1) begin n_err++; $display("FAIL tag_count: got %0d want 1", n_tag); end
   endtask

   task automatic test_reset_mid();
      idle_inputs(); out_ready = 0;
      in_valid = 1; in_mode = 1; in_tag = 1;
      for (int k = 0; k < 3; k++) begin in_data = 4'(k + 4); tick(); end
      rst = 1; tick();
      rst = 0; in_valid = 0; in_tag = 0; #1;
      n_vec++; if (out_valid !== 1'b0 || count !== 2'd0 || out_data !== 4'd0 || out_tag !== 1'b0 || in_ready !== 1'b1)
         begin n_err++; $display("FAIL reset_mid: got v=%b c=%0d d=%0d t=%b r=%b want 0 0 0 0 1", out_valid, count, out_data, out_tag, in_ready); end
      out_ready = 1; in_valid = 1; in_data = 4'd2; tick();
      in_valid = 0; tick(); tick();
      n_vec++; if (out_valid !== 1'b1 || out_data !== 4'd7 || count !== 2'd1) begin n_err++; $display("FAIL reset_mid_after: got v=%b d=%0d c=%0d want 1 7 1", out_valid, out_data, count); end
      tick();
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = W'($urandom);
         in_mode   = 1'($urandom);
         in_tag    = ($urandom_range(0, 15) == 0);
         stall_in  = {($urandom_range(0,3)==0), ($urandom_range(0,3)==0), ($urandom_range(0,3)==0)};
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
         if (drn) begin
            n_vec++; if (underflow || obs_data !== exp_data || obs_tag !== exp_tag) begin n_err++; $display("FAIL rand_out: cycle %0d got d=%0d t=%b want d=%0d t=%b uf=%b", k, obs_data, obs_tag, exp_data, exp_tag, underflow); end
         end
         n_vec++; if (count !== 2'(q_data.size())) begin n_err++; $display("FAIL rand_count: cycle %0d got %0d want %0d", k, count, q_data.size()); end
         if (hold_prev) begin
            n_vec++; if (out_valid !== 1'b1 || out_data !== hold_data || out_tag !== hold_tag) begin n_err++; $display("FAIL rand_hold: cycle %0d got v=%b d=%0d want v=1 d=%0d", k, out_valid, out_data, hold_data); end
         end
      end
      idle_inputs();
      for (int k = 0; k < 20 && q_data.size() != 0; k++) begin
         tick();
         if (drn) begin
            n_vec++; if (underflow || obs_data !== exp_data || obs_tag !== exp_tag) begin n_err++; $display("FAIL rand_drain: got d=%0d t=%b want d=%0d t=%b", obs_data, obs_tag, exp_data, exp_tag); end
         end
      end
      n_vec++; if (q_data.size() != 0 || out_valid !== 1'b0 || count !== 2'd0) begin n_err++; $display("FAIL rand_final: pending=%0d v=%b c=%0d want 0 0 0", q_data.size(), out_valid, count); end
   endtask

   initial begin
      rst = 1; idle_inputs();
      @(posedge clk); #1;
      test_reset();
      test_basic();
      test_full();
      test_stall();
      test_tag();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
